// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int ITER_COUNT = 32;
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic n);
    return n ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: signed add-shift-right (multiply)
// or restoring compare-subtract-shift-left (divide), chosen by is_div.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN:0]   hi_in,
  input  logic [XLEN-1:0] lo_in,
  input  logic [XLEN:0]   operand,
  output logic [XLEN:0]   hi_out,
  output logic [XLEN-1:0] lo_out
);

  logic [XLEN+1:0] addend;
  logic [XLEN+1:0] add_sum;
  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] sub_diff;

  always_comb begin
    // Multiply: hi/lo form a 65-bit product register shifted right arithmetically.
    addend   = lo_in[0] ? {operand[XLEN], operand} : '0;
    add_sum  = {hi_in[XLEN], hi_in} + addend;
    // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
    shifted  = {hi_in[XLEN-1:0], lo_in[XLEN-1]};
    sub_diff = {1'b0, shifted} - {1'b0, operand};
    if (is_div) begin
      hi_out = sub_diff[XLEN+1] ? shifted : sub_diff[XLEN:0];
      lo_out = {lo_in[XLEN-2:0], ~sub_diff[XLEN+1]};
    end else begin
      hi_out = add_sum[XLEN+1:1];
      lo_out = {add_sum[0], lo_in[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with writeback address tracking.
// Optional MULDIV_FAST_MUL_EN resolves multiplies in one cycle with a 33x33 product.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   ST_IDLE | waiting for start; kill has priority
//   ST_CALC | 32 shift-add or restoring-divide iterations
//   ST_DONE | one-cycle done pulse, result and wb_en valid
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_addr,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      wb_addr,
  output logic            wb_en
);

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN:0]   hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN:0]   opnd_q, opnd_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] corr_q, corr_d;
  logic            quot_neg_q, quot_neg_d;
  logic            rem_neg_q, rem_neg_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      wb_addr_q, wb_addr_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            wb_en_q, wb_en_d;

  logic [XLEN:0]   step_hi;
  logic [XLEN-1:0] step_lo;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div  (op_q[2]),
    .hi_in   (hi_q),
    .lo_in   (lo_q),
    .operand (opnd_q),
    .hi_out  (step_hi),
    .lo_out  (step_lo)
  );

  logic            div_signed, a_signed, b_signed;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_by_zero, div_ovf, fast_mul, special;
  logic [XLEN-1:0] fast_mul_res, special_res;

  always_comb begin
    div_signed  = op[2] && !op[0];
    a_signed    = (op != OP_MULHU);
    b_signed    = !op[1];
    a_mag       = neg_if(rs1_val, div_signed && rs1_val[XLEN-1]);
    b_mag       = neg_if(rs2_val, div_signed && rs2_val[XLEN-1]);
    div_by_zero = op[2] && (rs2_val == '0);
    div_ovf     = div_signed && (rs1_val == INT_MIN) && (rs2_val == '1);
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = (2*XLEN)'($signed({a_signed & rs1_val[XLEN-1], rs1_val}) *
                              $signed({b_signed & rs2_val[XLEN-1], rs2_val}));
  assign fast_mul     = !op[2];
  assign fast_mul_res = (op == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`else
  assign fast_mul     = 1'b0;
  assign fast_mul_res = '0;
`endif

  always_comb begin
    special = div_by_zero || div_ovf || fast_mul;
    if (fast_mul)
      special_res = fast_mul_res;
    else if (div_by_zero)
      special_res = op[1] ? rs1_val : DIV0_QUOT;
    else
      special_res = op[1] ? '0 : INT_MIN;
  end

  // Final fix-up applied to the last iteration's output.
  logic [XLEN-1:0] prod_hi, calc_res;

  always_comb begin
    // Multiplier low word was taken unsigned; a negative signed rs2 owes -rs1<<32.
    prod_hi = step_hi[XLEN-1:0] - corr_q;
    if (!op_q[2])
      calc_res = (op_q == OP_MUL) ? step_lo : prod_hi;
    else if (op_q[1])
      calc_res = neg_if(step_hi[XLEN-1:0], rem_neg_q);
    else
      calc_res = neg_if(step_lo, quot_neg_q);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    opnd_d     = opnd_q;
    op_d       = op_q;
    corr_d     = corr_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
    result_d   = result_q;
    wb_addr_d  = wb_addr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (!kill && start) begin
          op_d      = op;
          wb_addr_d = rd_addr;
          if (special) begin
            result_d = special_res;
            state_d  = ST_DONE;
          end else begin
            state_d = ST_CALC;
            cnt_d   = CNT_W'(ITER_COUNT);
            hi_d    = '0;
            if (op[2]) begin
              lo_d   = a_mag;
              opnd_d = {1'b0, b_mag};
            end else begin
              lo_d   = rs2_val;
              opnd_d = {a_signed & rs1_val[XLEN-1], rs1_val};
            end
            corr_d     = (b_signed && rs2_val[XLEN-1]) ? rs1_val : '0;
            quot_neg_d = div_signed && (rs1_val[XLEN-1] ^ rs2_val[XLEN-1]);
            rem_neg_d  = div_signed && rs1_val[XLEN-1];
          end
        end
      end
      ST_CALC: begin
        if (kill) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          hi_d  = step_hi;
          lo_d  = step_lo;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d  = ST_DONE;
            result_d = calc_res;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    wb_en_d = done_d && (wb_addr_d != 5'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      opnd_q     <= '0;
      op_q       <= '0;
      corr_q     <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      result_q   <= '0;
      wb_addr_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wb_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      opnd_q     <= opnd_d;
      op_q       <= op_d;
      corr_q     <= corr_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
      result_q   <= result_d;
      wb_addr_q  <= wb_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wb_en_q    <= wb_en_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign wb_addr = wb_addr_q;
  assign wb_en   = wb_en_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (both default and MULDIV_FAST_MUL_EN builds).
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1_val, rs2_val;
  logic [4:0]  rd_addr;
  logic        kill;
  logic        busy, done, wb_en;
  logic [31:0] result;
  logic [4:0]  wb_addr;

  int n_chk = 0;
  int n_err = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  muldiv_unit dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .rd_addr (rd_addr),
    .kill    (kill),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .wb_addr (wb_addr),
    .wb_en   (wb_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    @(negedge clk);
    start = 1'b1; op = o; rs1_val = a; rs2_val = b; rd_addr = rd;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts sampled cycles after the accept edge (accept edge counts as 1) until done.
  // poke_at > 0 fires a stray start (MUL 3*5) in that cycle.
  task automatic wait_done(input int poke_at, output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy === 1'b1) bcnt++;
      start = (lat == poke_at);
      if (lat == poke_at) begin
        op = 3'b000; rs1_val = 32'd3; rs2_val = 32'd5; rd_addr = 5'd9;
      end
    end while (done !== 1'b1 && lat < 60);
    start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input int exp_lat,
                        input logic [31:0] exp_res, input int poke_at);
    int lat, bcnt;
    issue(o, a, b, rd);
    wait_done(poke_at, lat, bcnt);
    chk({tag, "_lat"},    32'(lat), 32'(exp_lat));
    chk({tag, "_res"},    result, exp_res);
    chk({tag, "_waddr"},  {27'd0, wb_addr}, {27'd0, rd});
    chk({tag, "_wben"},   {31'd0, wb_en}, {31'd0, rd != 5'd0});
    chk({tag, "_busyn"},  32'(bcnt), 32'(exp_lat));
    @(negedge clk);
    chk({tag, "_idle"},   {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    int done_seen;
    reset = 1'b1; start = 1'b0; op = 3'b000; rs1_val = '0; rs2_val = '0;
    rd_addr = '0; kill = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_res",   result, 32'd0);
    chk("rst_waddr", {27'd0, wb_addr}, 32'd0);
    chk("rst_wben",  {31'd0, wb_en}, 32'd0);
    reset = 1'b0;

    run_op("mul_7_m3",  3'b000, 32'd7,         32'hFFFF_FFFD, 5'd5,  MUL_LAT, 32'hFFFF_FFEB, 0);
    run_op("mulhu_m1",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  MUL_LAT, 32'hFFFF_FFFE, 0);
    run_op("mulh_m1",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  MUL_LAT, 32'h0000_0000, 0);
    run_op("mulhsu_m1", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  MUL_LAT, 32'hFFFF_FFFF, 0);
    run_op("mul_m1",    3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  MUL_LAT, 32'h0000_0001, 0);

    run_op("div_m7_2",  3'b100, 32'hFFFF_FFF9, 32'd2, 5'd10, DIV_LAT, 32'hFFFF_FFFD, 0);
    run_op("rem_m7_2",  3'b110, 32'hFFFF_FFF9, 32'd2, 5'd11, DIV_LAT, 32'hFFFF_FFFF, 0);
    run_op("divu_100",  3'b101, 32'd100,       32'd7, 5'd12, DIV_LAT, 32'd14, 0);
    run_op("remu_100",  3'b111, 32'd100,       32'd7, 5'd13, DIV_LAT, 32'd2,  0);

    run_op("div_by0",   3'b100, 32'd20,        32'd0,         5'd14, 1, 32'hFFFF_FFFF, 0);
    run_op("remu_by0",  3'b111, 32'd20,        32'd0,         5'd15, 1, 32'd20, 0);
    run_op("div_ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 1, 32'h8000_0000, 0);
    run_op("rem_ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 1, 32'd0, 0);

    // Stray start mid-calculation must be dropped.
    run_op("ign_start", 3'b101, 32'd100, 32'd7, 5'd7, DIV_LAT, 32'd14, 10);
    repeat (3) @(negedge clk);
    chk("ign_no_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset during calculation.
    issue(3'b101, 32'd100, 32'd7, 5'd3);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_done", {31'd0, done}, 32'd0);
    chk("rstmid_wben", {31'd0, wb_en}, 32'd0);
    chk("rstmid_res",  result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op("mul_3_4", 3'b000, 32'd3, 32'd4, 5'd4, MUL_LAT, 32'd12, 0);

    // Kill during calculation: back to idle, no done, result kept.
    issue(3'b101, 32'd100, 32'd7, 5'd8);
    repeat (5) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_busy", {31'd0, busy}, 32'd0);
    chk("kill_done", {31'd0, done}, 32'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    chk("kill_quiet", 32'(done_seen), 32'd0);
    chk("kill_res",   result, 32'd12);

    run_op("mul_rd0", 3'b000, 32'd6, 32'd7, 5'd0, MUL_LAT, 32'd42, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
